// File: rtl/ms_tick_timer_if.sv
`default_nettype none
//== ms_tick_timer_if: control/status bundle between ms_tick_timer and its user ==
//== Rev 1.0 ==
interface ms_tick_timer_if #(
    parameter int CNT_W = 16
);
    logic             demo_mode;
    logic             start;
    logic             stop;
    logic             clear;
    logic             oneshot;
    logic [CNT_W-1:0] timeout_ms;
    logic             tick;
    logic             expire;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] elapsed_ms;
    logic             overflow;

    modport slave (
        input  demo_mode, start, stop, clear, oneshot, timeout_ms,
        output tick, expire, running, done, elapsed_ms, overflow
    );

    modport master (
        output demo_mode, start, stop, clear, oneshot, timeout_ms,
        input  tick, expire, running, done, elapsed_ms, overflow
    );
endinterface
`default_nettype wire

// File: rtl/ms_tick_timer.sv
`default_nettype none
//== ms_tick_timer: 1 ms prescaler, elapsed-ms counter and start/stop/clear timeout FSM ==
//== Rev 1.0 ==
module ms_tick_timer #(
    parameter int REAL_DIV = 50000,
    parameter int DEMO_DIV = 50,
    parameter int PRE_W    = 16,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    ms_tick_timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0] REAL_TERM = PRE_W'(REAL_DIV - 1);
    localparam logic [PRE_W-1:0] DEMO_TERM = PRE_W'(DEMO_DIV - 1);

    state_t           state_q;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] elapsed_q;
    logic [CNT_W-1:0] timeout_q;
    logic             oneshot_q;
    logic             tick_q;
    logic             expire_q;
    logic             running_q;
    logic             done_q;
    logic             overflow_q;

    logic [PRE_W-1:0] term_d;
    logic             pre_end_d;
    logic [CNT_W-1:0] n_d;
    logic             hit_d;

    // >= rather than == so a REAL->DEMO switch mid-count wraps immediately.
    always_comb begin
        term_d    = bus.demo_mode ? REAL_TERM : DEMO_TERM;
        pre_end_d = (pre_q >= term_d);
        n_d       = elapsed_q + CNT_W'(1);
        hit_d     = (timeout_q != '0) && (n_d == timeout_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pre_q      <= '0;
            elapsed_q  <= '0;
            timeout_q  <= '0;
            oneshot_q  <= 1'b0;
            tick_q     <= 1'b0;
            expire_q   <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            tick_q   <= 1'b0;
            expire_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    pre_q <= '0;
                    if (bus.clear) begin
                        state_q   <= S_IDLE;
                        elapsed_q <= '0;
                        running_q <= 1'b0;
                        done_q    <= 1'b0;
                    end else if (bus.start) begin
                        state_q    <= S_RUN;
                        timeout_q  <= bus.timeout_ms;
                        oneshot_q  <= bus.oneshot;
                        elapsed_q  <= '0;
                        overflow_q <= 1'b0;
                        running_q  <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bus.clear) begin
                        state_q   <= S_IDLE;
                        elapsed_q <= '0;
                        pre_q     <= '0;
                        running_q <= 1'b0;
                    end else if (bus.stop && !bus.start) begin
                        state_q   <= S_PAUSE;
                        running_q <= 1'b0;
                    end else if (pre_end_d) begin
                        pre_q  <= '0;
                        tick_q <= 1'b1;
                        if (hit_d) begin
                            expire_q <= 1'b1;
                            if (oneshot_q) begin
                                elapsed_q <= n_d;
                                state_q   <= S_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end else begin
                                elapsed_q <= '0;
                            end
                        end else begin
                            elapsed_q <= n_d;
                            if ((timeout_q == '0) && (n_d == '0)) begin
                                overflow_q <= 1'b1;
                            end
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.clear) begin
                        state_q   <= S_IDLE;
                        elapsed_q <= '0;
                        pre_q     <= '0;
                    end else if (bus.start) begin
                        state_q   <= S_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.tick       = tick_q;
    assign bus.expire     = expire_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.elapsed_ms = elapsed_q;
    assign bus.overflow   = overflow_q;
endmodule
`default_nettype wire

// File: doc/ms_tick_timer.md
Name: ms_tick_timer

Overview:
- Parametrised successor to the team's one-millisecond tick generator.
- A prescaler divides clk down to a 1 ms tick, using one of two divisors selected by demo_mode.
- The tick drives an elapsed-millisecond counter with a start/stop/clear control FSM, a programmable timeout, one-shot or periodic expiry, and a sticky overflow flag.
- Sits between the system clock and any game or control logic needing millisecond timing or timeouts.

Parameters:
- REAL_DIV, 50000, clk cycles per tick in real mode (50 MHz clock -> 1 ms).
- DEMO_DIV, 50, clk cycles per tick in demo mode.
- PRE_W, 16, prescaler width; must satisfy 2^PRE_W >= max(REAL_DIV, DEMO_DIV).
- CNT_W, 16, width of elapsed_ms and timeout_ms.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- demo_mode  input  1  0 = DEMO_DIV, 1 = REAL_DIV (same polarity as the existing timer).
- start  input  1  start, or resume from PAUSE.
- stop  input  1  pause counting.
- clear  input  1  abort and return to IDLE.
- oneshot  input  1  1 = stop at timeout; 0 = periodic reload. Sampled with start.
- timeout_ms  input  CNT_W  expiry count; 0 = no timeout (free run). Sampled with start.
- tick  output  1  one-cycle pulse per elapsed ms while RUN.
- expire  output  1  one-cycle pulse when the timeout is reached.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- elapsed_ms  output  CNT_W  milliseconds counted since start.
- overflow  output  1  sticky; set when elapsed_ms wraps in free run.

Behaviour:
- Reset: state = IDLE; prescaler = 0; elapsed_ms = 0; tick = 0; expire = 0; running = 0; done = 0; overflow = 0; latched timeout = 0; latched oneshot = 0.
- All outputs are registered.
- div = demo_mode ? REAL_DIV : DEMO_DIV, evaluated every cycle.
- Terminal condition is prescaler >= div-1, not ==, so that switching REAL->DEMO mid-count wraps on the next cycle instead of running to 2^PRE_W.
- Prescaler advances only in RUN. It holds in PAUSE and is zeroed in IDLE and DONE, and on start from IDLE/DONE.
- Command priority: clear > start > stop. Each is level-sampled on every edge.
- States:
  - IDLE: start -> RUN. Latch timeout_ms and oneshot; zero elapsed_ms, prescaler and overflow.
  - RUN:
    - clear -> IDLE, elapsed_ms = 0.
    - stop (no start) -> PAUSE.
    - start while in RUN is ignored.
  - PAUSE:
    - start -> RUN; resume with the prescaler and elapsed_ms preserved; latches are not reloaded.
    - clear -> IDLE.
    - stop is ignored.
  - DONE:
    - done = 1 and elapsed_ms holds the timeout value.
    - start -> RUN as from IDLE.
    - clear -> IDLE.
- Tick timing: in RUN, on an edge where the prescaler is terminal:
  - prescaler <= 0;
  - tick <= 1 for one cycle;
  - n = elapsed_ms + 1 (mod 2^CNT_W).
- Expiry:
  - Condition: latched timeout != 0 and n == latched timeout.
  - One-shot: elapsed_ms <= n; expire <= 1; state -> DONE.
  - Periodic: elapsed_ms <= 0; expire <= 1; remain in RUN.
- Free run (latched timeout == 0): elapsed_ms <= n. A wrap from 2^CNT_W-1 to 0 sets overflow, which stays set until the next start from IDLE/DONE, or until reset.
- Latency: the first tick is high in the cycle after the DIV-th rising edge following the edge that sampled start.
- stop and a terminal prescaler on the same edge: stop wins. No tick, the prescaler holds its value, and the tick completes after resume.
- clear and tick/expire on the same edge: clear wins. tick = expire = 0.
- timeout_ms = 1: expire on the first tick.
- Changing timeout_ms or oneshot while RUN has no effect until the next start from IDLE/DONE.
- Reset mid-operation returns every output to its reset value on that edge.

Test Plan:
- DEMO_DIV = 50, demo_mode = 0, timeout = 0; start pulse at edge 0 -> tick at edges 50, 100, 150; elapsed_ms = 1, 2, 3; running = 1.
- timeout = 3, oneshot = 1, demo -> expire and tick at edge 150; done = 1; elapsed_ms = 3 and held; no further ticks. A second start restarts from 0.
- timeout = 2, oneshot = 0 -> expire at edges 100, 200, 300; elapsed_ms sequence 1, 0, 1, 0; running stays 1.
- Pause and clear:
  - stop at edge 120 (prescaler = 20), start at edge 200 -> next tick at edge 230, elapsed_ms = 3.
  - clear at any time -> elapsed_ms = 0, IDLE next cycle.
- Mode switch: demo_mode 1 -> 0 with prescaler = 30000 -> tick on the next edge; subsequent ticks every 50 cycles.
- Overflow: CNT_W = 4, free run -> after 16 ticks elapsed_ms = 0 and overflow = 1. overflow persists through pause; reset clears all outputs.
